// File: rtl/decoder_pkg.sv
// Shared types and defaults for the pad-input symbol decoder path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package decoder_pkg;

    // Width of one captured pad symbol
    localparam int SYM_W = 7;

    // Default number of identical synchronized samples before a symbol is accepted
    localparam int DEF_STABLE_CYCLES = 3;

    // Default symbol FIFO depth (power of two, 2..16)
    localparam int DEF_DEPTH = 4;

    // Capture FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_COMMIT = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    // Occupancy counter width: one extra bit so that "full" is distinguishable from "empty"
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/decoder_sym_fifo.sv
// Symbol FIFO between the capture FSM and the downstream decoder.
// Latency: a push is visible at the head one edge later; no write-to-read bypass.
// Backpressure: pop ignored when empty; push dropped when full unless a pop happens in the same cycle.
module decoder_sym_fifo
    import decoder_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int W     = SYM_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic                      pop,
    input  logic [W-1:0]              wdata,
    output logic [W-1:0]              rdata,
    output logic [level_w(DEPTH)-1:0] level,
    output logic                      full,
    output logic                      empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic          push_ok;
    logic          pop_ok;

    // Occupancy, flags and accepted push/pop; a pop frees a slot for a same-cycle push when full
    always_comb begin
        level   = wptr_q - rptr_q;
        empty   = (level == '0);
        full    = (level == PW'(DEPTH));
        pop_ok  = pop && !empty;
        push_ok = push && (!full || pop_ok);
        wptr_d  = wptr_q + PW'(push_ok);
        rptr_d  = rptr_q + PW'(pop_ok);
        rdata   = empty ? '0 : mem_q[rptr_q[AW-1:0]];
    end

    // Pointer registers; extra MSB lets them wrap modulo 2*DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage write; contents are don't-care until covered by the pointers
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/decoder_in_capture.sv
// Synchronizes raw pad bits, debounces them into symbols and queues new symbols for the decoder.
// Latency: 2 sync + STABLE_CYCLES settle + 1 commit edges from stable io_in to sym_valid on an empty FIFO.
// Backpressure: sym_valid/sym_ready handshake; a commit into a full FIFO without a pop is dropped and flagged.
// Optional: DECODER_IN_PARITY_EN enables even-parity checking (io_in[6] over io_in[5:0]) and the parity_err port.
module decoder_in_capture
    import decoder_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int DEPTH         = DEF_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [SYM_W-1:0]          io_in,
    output logic [SYM_W-1:0]          sym_data,
    output logic                      sym_valid,
    input  logic                      sym_ready,
    output logic [level_w(DEPTH)-1:0] fifo_level,
    output logic                      overflow,
`ifdef DECODER_IN_PARITY_EN
    output logic                      parity_err,
`endif
    output logic                      ovf_sticky
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);

    logic [SYM_W-1:0] sync1_q, sync1_d;
    logic [SYM_W-1:0] sync_q, sync_d;
    logic [SYM_W-1:0] cand_q, cand_d;
    logic [SYM_W-1:0] last_q, last_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    cnt_inc;
    state_t           state_q, state_d;
    logic             ovf_sticky_q, ovf_sticky_d;
    logic             push_req;
    logic             fifo_full;
    logic             fifo_empty;
`ifdef DECODER_IN_PARITY_EN
    logic             parity_ok;
`endif

    // Two-stage synchronizer inputs; only the second stage is consumed
    always_comb begin
        sync1_d = io_in;
        sync_d  = sync1_q;
    end

    // Synchronizer flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync_q  <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync_q  <= sync_d;
        end
    end

    // FSM state and datapath registers; reset discards any symbol in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cand_q       <= '0;
            last_q       <= '0;
            cnt_q        <= '0;
            ovf_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cand_q       <= cand_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
            ovf_sticky_q <= ovf_sticky_d;
        end
    end

    // Next state: settle on a candidate, commit it once, then hold until the input moves away
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        cnt_inc = cnt_q + CW'(1);
        case (state_q)
            ST_IDLE: begin
                cand_d  = sync_q;
                cnt_d   = CW'(1);
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (sync_q != cand_q) begin
                    cand_d = sync_q;
                    cnt_d  = CW'(1);
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CW'(STABLE_CYCLES)) begin
                        // A value that settles back to the last committed one is a glitch
                        state_d = (cand_q == last_q) ? ST_HOLD : ST_COMMIT;
                    end
                end
            end
            ST_COMMIT: begin
                last_d  = cand_q;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (sync_q != last_q) begin
                    cand_d  = sync_q;
                    cnt_d   = CW'(1);
                    state_d = ST_SETTLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs: one-cycle push in COMMIT, drop detection and sticky overflow
    always_comb begin
`ifdef DECODER_IN_PARITY_EN
        parity_ok  = ~^cand_q;
        parity_err = (state_q == ST_COMMIT) && !parity_ok;
        push_req   = (state_q == ST_COMMIT) && parity_ok;
`else
        push_req   = (state_q == ST_COMMIT);
`endif
        // Full implies non-empty, so sym_ready alone means a pop frees the slot
        overflow     = push_req && fifo_full && !sym_ready;
        ovf_sticky_d = ovf_sticky_q || overflow;
        ovf_sticky   = ovf_sticky_q;
        sym_valid    = !fifo_empty;
    end

    decoder_sym_fifo #(
        .DEPTH (DEPTH),
        .W     (SYM_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_req),
        .pop   (sym_ready),
        .wdata (cand_q),
        .rdata (sym_data),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_decoder_in_capture.sv
// Self-checking bench for decoder_in_capture: directed scenarios plus randomized runs vs a run-length model.
// Latency: n/a.
// Backpressure: sym_ready driven directly by the bench.
module tb_decoder_in_capture;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] io_in = '0;
    logic       sym_ready = 1'b0;
    logic [6:0] sym_data;
    logic       sym_valid;
    logic [2:0] fifo_level;
    logic       overflow;
    logic       ovf_sticky;
`ifdef DECODER_IN_PARITY_EN
    logic       parity_err;
`endif

    int checks = 0;
    int errors = 0;

    decoder_in_capture #(
        .STABLE_CYCLES (3),
        .DEPTH         (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .io_in      (io_in),
        .sym_data   (sym_data),
        .sym_valid  (sym_valid),
        .sym_ready  (sym_ready),
        .fifo_level (fifo_level),
        .overflow   (overflow),
`ifdef DECODER_IN_PARITY_EN
        .parity_err (parity_err),
`endif
        .ovf_sticky (ovf_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and land 1 time unit past the last one
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    // Whether a settled symbol is allowed into the FIFO
    function automatic logic par_ok(input logic [6:0] v);
`ifdef DECODER_IN_PARITY_EN
        return ~^v;
`else
        return 1'b1;
`endif
    endfunction

    initial begin
        int         ovf_cnt;
        int         prev;
        int         len;
        logic [6:0] v;
        logic [6:0] model_last;
        logic [6:0] stim[$];
        logic [6:0] expq[$];
        logic [6:0] seq5[5];

        // ---------- reset state and first-symbol latency ----------
        io_in = 7'b1001011;
        rst_n = 1'b0;
        tick(2);
        chk("rst_valid", sym_valid, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_sticky", ovf_sticky, 0);
        chk("rst_data", sym_data, 0);
        rst_n = 1'b1;
        tick(5);
        chk("lat_edge5_valid", sym_valid, 0);
        tick(1);
        chk("lat_edge6_valid", sym_valid, 1);
        chk("lat_edge6_data", sym_data, 7'h4B);
        chk("lat_edge6_level", fifo_level, 1);
        tick(10);
        chk("held_no_repush", fifo_level, 1);

        // ---------- one-cycle glitches are filtered ----------
        repeat (2) begin
            io_in = 7'h00;
            tick(1);
            io_in = 7'h4B;
            tick(10);
        end
        chk("glitch_level", fifo_level, 1);
        chk("glitch_data", sym_data, 7'h4B);

        // ---------- push+pop at level 1 ----------
        io_in = 7'h5A;
        tick(5);
        sym_ready = 1'b1;
        tick(1);
        sym_ready = 1'b0;
        chk("lvl1_pushpop_level", fifo_level, 1);
        chk("lvl1_pushpop_head", sym_data, 7'h5A);

        // ---------- pop to empty, then ready while empty ----------
        sym_ready = 1'b1;
        tick(1);
        chk("pop_to_empty", fifo_level, 0);
        tick(3);
        chk("empty_ready_level", fifo_level, 0);
        chk("empty_ready_valid", sym_valid, 0);
        sym_ready = 1'b0;

        // ---------- overflow on the fifth stalled commit ----------
        seq5 = '{7'h11, 7'h22, 7'h33, 7'h44, 7'h55};
        ovf_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            io_in = seq5[i];
            for (int c = 0; c < 8; c++) begin
                tick(1);
                if (overflow === 1'b1) ovf_cnt++;
            end
        end
        chk("ovf_pulses", ovf_cnt, 1);
        chk("ovf_level", fifo_level, 4);
        chk("ovf_sticky", ovf_sticky, 1);
        chk("ovf_head", sym_data, 7'h11);

        // ---------- full with ready on the commit cycle ----------
        io_in = 7'h66;
        tick(5);
        chk("full_commit_noready_ovf", overflow, 1);
        sym_ready = 1'b1;
        #1;
        chk("full_commit_ready_ovf", overflow, 0);
        tick(1);
        sym_ready = 1'b0;
        chk("full_pushpop_level", fifo_level, 4);
        chk("full_pushpop_head", sym_data, 7'h22);

        // ---------- reset during settle discards the pending symbol ----------
        io_in = 7'h2A;
        tick(4);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", sym_valid, 0);
        chk("midrst_level", fifo_level, 0);
        chk("midrst_sticky", ovf_sticky, 0);
        chk("midrst_data", sym_data, 0);
        tick(1);
        rst_n = 1'b1;
        tick(5);
        chk("postrst_edge5_valid", sym_valid, 0);
        tick(1);
        chk("postrst_edge6_valid", sym_valid, par_ok(7'h2A));
        chk("postrst_edge6_data", sym_data, par_ok(7'h2A) ? 7'h2A : 7'h00);

`ifdef DECODER_IN_PARITY_EN
        // ---------- parity filtering ----------
        io_in = 7'b0001011;
        do_reset();
        tick(5);
        chk("par_err_pulse", parity_err, 1);
        tick(1);
        chk("par_err_clear", parity_err, 0);
        chk("par_err_nopush", sym_valid, 0);
        io_in = 7'b1001011;
        tick(6);
        chk("par_ok_push", sym_valid, 1);
        chk("par_ok_data", sym_data, 7'h4B);
`endif

        // ---------- randomized runs against a run-length model ----------
        // Runs are either short glitches (1-2 cycles) or long holds (5-8 cycles);
        // a long hold yields a symbol when it differs from the last accepted value.
        prev = -1;
        model_last = 7'h00;
        for (int r = 0; r < 40; r++) begin
            do v = 7'($urandom_range(0, 127)); while (int'(v) == prev);
            prev = int'(v);
            if (r == 39) len = 12;
            else if ($urandom_range(0, 2) == 0) len = $urandom_range(1, 2);
            else len = $urandom_range(5, 8);
            for (int k = 0; k < len; k++) stim.push_back(v);
            if (len >= 5 && v != model_last) begin
                if (par_ok(v)) expq.push_back(v);
                model_last = v;
            end
        end

        io_in = stim[0];
        do_reset();
        ovf_cnt = 0;
        for (int i = 0; i < stim.size() + 20; i++) begin
            if (i < stim.size()) io_in = stim[i];
            sym_ready = (i >= stim.size() || (i % 2) == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            if (overflow === 1'b1) ovf_cnt++;
            if (sym_valid === 1'b1 && sym_ready) begin
                if (expq.size() == 0) chk("rnd_unexpected_pop", sym_valid, 0);
                else chk("rnd_data", sym_data, expq.pop_front());
            end
            tick(1);
        end
        sym_ready = 1'b0;
        chk("rnd_remaining", expq.size(), 0);
        chk("rnd_ovf", ovf_cnt, 0);
        chk("rnd_drained", sym_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
